multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM of the multicycle RISC-V core; sits directly upstream of the datapath and drives all of its enables and mux selects.
- Consumes Op, Fun3, Fun75 and the ALU Zero flag from the datapath; produces PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUControl.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- Op  input  7  instruction opcode, Instr[6:0]
- Fun3  input  3  Instr[14:12]
- Fun75  input  1  Instr[30]
- Zero  input  1  ALU zero flag, same cycle as ALUResult
- PCWrite  output  1  PC register load enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- MemWrite  output  1  memory write enable
- IRWrite  output  1  Instr/OldPc load enable
- RegWrite  output  1  register-file write enable
- ResultSrc  output  2  Result select: 00 = ALUResult, 01 = Data, 10 = ALUOut
- ALUSrcA  output  2  SrcA select: 00 = PC, 01 = OldPc, 10 = A
- ALUSrcB  output  2  SrcB select: 00 = WriteData, 01 = ImmExt, 10 = constant 4
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt

Behaviour:
- Moore FSM; outputs are decoded from the current state only, except ImmSrc, ALUControl and PCWrite.
- States:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (target into ALUOut). Next by Op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other Op -> FETCH (treated as NOP)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if Op=0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=10. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=10, MemWrite=1. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next: ALUWB.
  - ALUWB: ResultSrc=10, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=10, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, PCUpdate=1. Next: ALUWB.
- PCWrite = PCUpdate | (Branch & Zero). Zero is sampled combinationally during BEQ only.
- ALU decode:
  - ALUOp add -> 000; sub -> 001.
  - funct path by Fun3: 000 -> sub if (Fun75 & Op[5]) else add; 010 -> slt; 110 -> or; 111 -> and; others -> add.
- ImmSrc is decoded from Op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
- Latency in cycles including FETCH: lw 5; sw, R, I and jal 4; beq 3; illegal 2.
- Reset: state <= FETCH on any Clk edge with Reset=1, including mid-instruction. While Reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0; mux selects show their FETCH values.
- No enable output is ever X; unused selects are driven 00.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Adds output IllegalInstr (1 bit) and state TRAP.
  - DECODE with an unsupported Op -> TRAP.
  - In TRAP: all enables are 0 and IllegalInstr=1; the FSM stays in TRAP until Reset.
  - IllegalInstr is 0 in all other states.
- Undefined: no port, no TRAP state; unsupported Op returns to FETCH as above.

Decomposition:
- Package riscv_mc_pkg holds:
  - state enum
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUSrcA/B, ResultSrc and ImmSrc select codes
  - ALUControl codes
  - ALUOp enum: add, sub, funct
- One sub-module, alu_decoder: ALUOp, Fun3, Fun75, Op[5] -> ALUControl (combinational).

Test Plan:
- Reset held 2 cycles mid-EXECR -> PCWrite=IRWrite=RegWrite=MemWrite=0 while high; first cycle after release is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- Op=0000011 -> FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (RegWrite=1, ResultSrc=01), then FETCH; ImmSrc=00 throughout.
- Op=0110011, Fun3=000, Fun75=1 -> EXECR with ALUControl=001; Fun75=0 -> 000. Op=0010011, Fun3=000, Fun75=1 -> 000 (addi, never sub).
- Op=1100011 with Zero=1 in BEQ -> PCWrite=1, ResultSrc=10, ImmSrc=10; with Zero=0 -> PCWrite=0; next state FETCH in both cases.
- Op=1101111 -> JAL with PCWrite=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11, then ALUWB with RegWrite=1, ResultSrc=10.
- Op=1111111 -> FETCH follows DECODE with no write enables asserted; with ILLEGAL_TRAP_EN, IllegalInstr=1 and the FSM stays in TRAP for 10 or more cycles until Reset.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mc_pkg
// Brief    : Shared encodings for the multicycle RISC-V control path.
//            The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Brief    : Maps the FSM's ALUOp plus funct fields onto an ALUControl code.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [2:0] fun3_i,
  input  logic       fun75_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (fun3_i)
          // Op[5] separates R-type sub from addi, whose Instr[30] is immediate data
          3'b000:  alu_control_o = (fun75_i && op5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore control FSM for the multicycle RISC-V core (lw, sw, R, I,
//            beq, jal). Define ILLEGAL_TRAP_EN to add the TRAP state and the
//            IllegalInstr output.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] Op,
  input  logic [2:0] Fun3,
  input  logic       Fun75,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       IllegalInstr
`endif
);

  state_t state_q, state_d;
  aluop_t w_aluop;
  logic   w_branch;
  logic   w_pc_update;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    w_aluop     = ALUOP_ADD;
    w_branch    = 1'b0;
    w_pc_update = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALU;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_WD;
`ifdef ILLEGAL_TRAP_EN
    IllegalInstr = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        IRWrite     = 1'b1;
        w_pc_update = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        w_aluop = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_A;
        w_aluop   = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        w_branch  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALUOUT;
        w_pc_update = 1'b1;
        state_d     = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        IllegalInstr = 1'b1;
        state_d      = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset presents the FETCH selects but suppresses every write enable
    if (Reset) begin
      w_aluop     = ALUOP_ADD;
      w_branch    = 1'b0;
      w_pc_update = 1'b0;
      AdrSrc      = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      ResultSrc   = RES_ALU;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_FOUR;
`ifdef ILLEGAL_TRAP_EN
      IllegalInstr = 1'b0;
`endif
    end
  end

  assign PCWrite = w_pc_update | (w_branch & Zero);

  always_comb begin
    ImmSrc = IMM_I;
    case (Op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i       (w_aluop),
    .fun3_i        (Fun3),
    .fun75_i       (Fun75),
    .op5_i         (Op[5]),
    .alu_control_o (ALUControl)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Randomized self-checking bench; expected outputs come from a
//            per-instruction phase list built from the instruction semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
  } ctl_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [6:0] Op;
  logic [2:0] Fun3;
  logic       Fun75;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
`ifdef ILLEGAL_TRAP_EN
  logic       IllegalInstr;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 Clk = ~Clk;

  multicycle_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Op         (Op),
    .Fun3       (Fun3),
    .Fun75      (Fun75),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
`ifdef ILLEGAL_TRAP_EN
    ,
    .IllegalInstr (IllegalInstr)
`endif
  );

  ctl_t w_dut_ctl;
  assign w_dut_ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] funct_of(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    case (f3)
      3'b000:  return (f75 && op[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for one named phase of an instruction
  function automatic ctl_t model(input string ph, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f75, input logic z);
    ctl_t c;
    c     = '0;
    c.imm = imm_of(op);
    case (ph)
      "F":   begin c.irw = 1; c.pcw = 1; c.sb = 2'b10; end
      "RST": begin c.sb = 2'b10; end
      "D":   begin c.sa = 2'b01; c.sb = 2'b01; end
      "MA":  begin c.sa = 2'b10; c.sb = 2'b01; end
      "MR":  begin c.adr = 1; c.res = 2'b10; end
      "MWB": begin c.res = 2'b01; c.rw = 1; end
      "MW":  begin c.adr = 1; c.res = 2'b10; c.mw = 1; end
      "ER":  begin c.sa = 2'b10; c.sb = 2'b00; c.alu = funct_of(op, f3, f75); end
      "EI":  begin c.sa = 2'b10; c.sb = 2'b01; c.alu = funct_of(op, f3, f75); end
      "WB":  begin c.res = 2'b10; c.rw = 1; end
      "B":   begin c.sa = 2'b10; c.alu = 3'b001; c.res = 2'b10; c.pcw = z; end
      "J":   begin c.sa = 2'b01; c.sb = 2'b10; c.res = 2'b10; c.pcw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic step(input string ph, input logic [6:0] op, input logic [2:0] f3,
                      input logic f75, input int zf, input logic rst);
    Reset = rst;
    Op    = op;
    Fun3  = f3;
    Fun75 = f75;
    Zero  = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
    @(negedge Clk);
    check_eq($sformatf("%s op=%b f3=%b f75=%b z=%b", ph, op, f3, f75, Zero),
             32'(w_dut_ctl), 32'(model(ph, op, f3, f75, Zero)));
`ifdef ILLEGAL_TRAP_EN
    check_eq($sformatf("IllegalInstr %s op=%b", ph, op), 32'(IllegalInstr), 32'(ph == "T"));
`endif
    @(posedge Clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75, input int zf);
    string seq[$];
    case (op)
      7'b0000011: seq = '{"F", "D", "MA", "MR", "MWB"};
      7'b0100011: seq = '{"F", "D", "MA", "MW"};
      7'b0110011: seq = '{"F", "D", "ER", "WB"};
      7'b0010011: seq = '{"F", "D", "EI", "WB"};
      7'b1100011: seq = '{"F", "D", "B"};
      7'b1101111: seq = '{"F", "D", "J", "WB"};
      default:    seq = '{"F", "D"};
    endcase
    foreach (seq[i]) step(seq[i], op, f3, f75, zf, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    if (seq.size() == 2) begin
      for (int k = 0; k < 12; k++) step("T", op, f3, f75, -1, 1'b0);
      step("RST", op, f3, f75, -1, 1'b1);
    end
`endif
  endtask

  logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    Reset = 1'b1; Op = '0; Fun3 = '0; Fun75 = 1'b0; Zero = 1'b0;
    @(posedge Clk);
    #1;
    step("RST", 7'b0000000, 3'b000, 1'b0, -1, 1'b1);
    step("RST", 7'b0000011, 3'b000, 1'b0, -1, 1'b1);

    run_instr(7'b0000011, 3'b010, 1'b0, -1);
    run_instr(7'b0110011, 3'b000, 1'b1, -1);
    run_instr(7'b0110011, 3'b000, 1'b0, -1);
    run_instr(7'b0010011, 3'b000, 1'b1, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1);
    run_instr(7'b1100011, 3'b000, 1'b0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, -1);

    // Reset held two cycles while the FSM sits in EXECR
    step("F",  7'b0110011, 3'b110, 1'b0, -1, 1'b0);
    step("D",  7'b0110011, 3'b110, 1'b0, -1, 1'b0);
    step("RST", 7'b0110011, 3'b110, 1'b0, -1, 1'b1);
    step("RST", 7'b0110011, 3'b110, 1'b0, -1, 1'b1);

    for (int n = 0; n < 80; n++) begin
      int         idx;
      logic [6:0] op;
      idx = $urandom_range(0, 6);
      op  = (idx == 6) ? 7'($urandom) : ops[idx];
      run_instr(op, 3'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
